// File: rtl/vga_sync_rx.sv
// -----------------------------------------------------------------------------
// vga_sync_rx
//
// Receive-side VGA timing recovery. Raw active-low hsync/vsync from an external
// or looped-back timing source are synchronised into the clk domain and used to
// regenerate the same h/v/visible/frame coordinates as the on-chip generator.
// A lock state machine qualifies the received timing against the mode given by
// the parameters, so capture/overlay logic can trust the coordinates.
//
// Ports
//   clk       in   pixel clock
//   reset_n   in   asynchronous active-low reset
//   hsync_in  in   raw hsync, active-low, asynchronous to clk
//   vsync_in  in   raw vsync, active-low, asynchronous to clk
//   h         out  recovered pixel counter, 0..HFULL-1
//   v         out  recovered line counter, 0..VFULL-1
//   visible   out  locked && h < HRES && v < VRES
//   locked    out  received timing qualified
//   sync_err  out  one-clock pulse for each cycle containing an error event
//   frame     out  frame counter, wraps 255 -> 0
// -----------------------------------------------------------------------------
module vga_sync_rx #(
  parameter int HRES        = 640,
  parameter int HF          = 16,
  parameter int HS          = 96,
  parameter int HB          = 48,
  parameter int VRES        = 480,
  parameter int VF          = 10,
  parameter int VS          = 2,
  parameter int VB          = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       visible,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] frame
);

  localparam int HFULL = HRES + HF + HS + HB;
  localparam int VFULL = VRES + VF + VS + VB;

  // Counter values at which the sync edges are expected. The h values are
  // where the counter sits when the synchronised edge is seen, which makes the
  // recovered h equal to the source counter delayed by the synchroniser depth.
  localparam logic [9:0] H_LAST  = 10'(HFULL - 1);
  localparam logic [9:0] H_LEAD  = 10'(HRES + HF);
  localparam logic [9:0] H_LOAD  = 10'(HRES + HF + 1);
  localparam logic [9:0] H_TRAIL = 10'(HRES + HF + HS);
  localparam logic [9:0] H_VIS   = 10'(HRES);
  localparam logic [9:0] V_LAST  = 10'(VFULL - 1);
  localparam logic [9:0] V_LEAD  = 10'(VRES + VF);
  localparam logic [9:0] V_TRAIL = 10'(VRES + VF + VS);
  localparam logic [9:0] V_VIS   = 10'(VRES);
  localparam logic [3:0] LOCK_CNT = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH,
    ACQUIRE,
    LOCKED
  } lock_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers plus one history flop per signal for edge detection.
  // ---------------------------------------------------------------------------
  logic hs_meta, hs_s, hs_prev;
  logic vs_meta, vs_s, vs_prev;

  // NOTE: the synchroniser flops reset to 1 (the inactive sync level) so that
  // reset release never looks like a leading edge; and every stage uses
  // non-blocking assignment so the chain shifts by exactly one flop per clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_meta <= 1'b1;
      hs_s    <= 1'b1;
      hs_prev <= 1'b1;
      vs_meta <= 1'b1;
      vs_s    <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      hs_meta <= hsync_in;
      hs_s    <= hs_meta;
      hs_prev <= hs_s;
      vs_meta <= vsync_in;
      vs_s    <= vs_meta;
      vs_prev <= vs_s;
    end
  end

  // Active-low syncs: leading edge is 1->0, trailing edge is 0->1.
  logic hs_lead, hs_trail, vs_lead, vs_trail;
  assign hs_lead  = hs_prev & ~hs_s;
  assign hs_trail = ~hs_prev & hs_s;
  assign vs_lead  = vs_prev & ~vs_s;
  assign vs_trail = ~vs_prev & vs_s;

  // ---------------------------------------------------------------------------
  // Free-running coordinate counters with sync-edge correction.
  // A corrected hs edge replaces the line wrap, so the line only advances when
  // the counter genuinely rolls over.
  // ---------------------------------------------------------------------------
  logic h_wrap, v_wrap;
  assign h_wrap = (h == H_LAST) && !hs_lead;
  assign v_wrap = h_wrap && (v == V_LAST) && !vs_lead;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h     <= '0;
      v     <= '0;
      frame <= '0;
    end else begin
      if (hs_lead) begin
        h <= H_LOAD;
      end else if (h == H_LAST) begin
        h <= '0;
      end else begin
        h <= h + 10'd1;
      end

      if (vs_lead) begin
        v <= V_LEAD;
      end else if (h_wrap) begin
        v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
      end

      if (v_wrap) begin
        frame <= frame + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timing error events, evaluated every clock regardless of lock state.
  // ---------------------------------------------------------------------------
  logic h_at_lead, v_at_lead, v_at_trail;
  logic ev_a, ev_b, ev_c, ev_d, ev_e, ev_f;
  logic err;

  assign h_at_lead  = (h == H_LEAD);
  assign v_at_lead  = (v == V_LEAD) && (h == 10'd0);
  assign v_at_trail = (v == V_TRAIL) && (h == 10'd0);

  assign ev_a = hs_lead && !h_at_lead;        // hsync arrived early or late
  assign ev_b = h_at_lead && !hs_lead;        // expected hsync missing
  assign ev_c = hs_trail && (h != H_TRAIL);   // wrong hsync width
  assign ev_d = vs_lead && !v_at_lead;        // vsync arrived early or late
  assign ev_e = v_at_lead && !vs_lead;        // expected vsync missing
  assign ev_f = vs_trail && !v_at_trail;      // wrong vsync width

  assign err = ev_a | ev_b | ev_c | ev_d | ev_e | ev_f;

  // ---------------------------------------------------------------------------
  // Lock state machine. good counts consecutive clean frames in ACQUIRE; clean
  // tracks whether the frame currently being received has seen any error.
  // An error in the same cycle as a vs leading edge belongs to the frame that
  // edge closes.
  // ---------------------------------------------------------------------------
  lock_state_t state;
  logic [3:0]  good;
  logic        clean;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEARCH;
      good     <= '0;
      clean    <= 1'b1;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      sync_err <= err;

      case (state)
        SEARCH: begin
          // Errors on the edge that starts acquisition are deliberately ignored.
          if (vs_lead) begin
            state <= ACQUIRE;
            good  <= '0;
            clean <= 1'b1;
          end
        end

        ACQUIRE: begin
          if (vs_lead) begin
            if (clean && !err) begin
              good <= good + 4'd1;
              if (good + 4'd1 == LOCK_CNT) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good <= '0;
            end
            clean <= 1'b1;
          end else if (err) begin
            clean <= 1'b0;
          end
        end

        LOCKED: begin
          if (err) begin
            state  <= SEARCH;
            locked <= 1'b0;
            good   <= '0;
          end
        end

        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
          good   <= '0;
          clean  <= 1'b1;
        end
      endcase
    end
  end

  assign visible = locked && (h < H_VIS) && (v < V_VIS);

endmodule

// File: tb/tb_vga_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_rx
//
// Self-checking bench for vga_sync_rx. A same-clock reference generator with
// combinational active-low syncs drives the receiver; its counters, delayed by
// two clocks, are the expected recovered coordinates once locked. A small mode
// keeps whole frames short enough to run the 256-frame wrap case.
// -----------------------------------------------------------------------------
module tb_vga_sync_rx;

  localparam int HRES = 6;
  localparam int HF   = 2;
  localparam int HS   = 2;
  localparam int HB   = 2;
  localparam int VRES = 4;
  localparam int VF   = 2;
  localparam int VS   = 2;
  localparam int VB   = 2;
  localparam int LOCK_FRAMES = 2;
  localparam int HFULL = HRES + HF + HS + HB;   // 12
  localparam int VFULL = VRES + VF + VS + VB;   // 10
  localparam int FRAME_CYC = HFULL * VFULL;     // 120

  logic       clk = 1'b0;
  logic       reset_n;
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] h;
  logic [9:0] v;
  logic       visible;
  logic       locked;
  logic       sync_err;
  logic [7:0] frame;

  always #5 clk = ~clk;

  vga_sync_rx #(
    .HRES(HRES), .HF(HF), .HS(HS), .HB(HB),
    .VRES(VRES), .VF(VF), .VS(VS), .VB(VB),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .h        (h),
    .v        (v),
    .visible  (visible),
    .locked   (locked),
    .sync_err (sync_err),
    .frame    (frame)
  );

  // ---------------------------------------------------------------------------
  // Reference generator and its two-clock-delayed copy.
  // ---------------------------------------------------------------------------
  logic [9:0] gen_h, gen_v, gh_d1, gh_d2, gv_d1, gv_d2;
  logic [7:0] gen_frame, gf_d1, gf_d2;
  logic       hs_gen, vs_gen, hs_gen_d1;
  logic [9:0] gen_vs;
  logic       hs_shift, hs_stuck;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_h <= '0; gen_v <= '0; gen_frame <= '0;
      gh_d1 <= '0; gh_d2 <= '0; gv_d1 <= '0; gv_d2 <= '0;
      gf_d1 <= '0; gf_d2 <= '0;
      hs_gen_d1 <= 1'b1;
    end else begin
      if (gen_h == 10'(HFULL - 1)) begin
        gen_h <= '0;
        if (gen_v == 10'(VFULL - 1)) begin
          gen_v     <= '0;
          gen_frame <= gen_frame + 8'd1;
        end else begin
          gen_v <= gen_v + 10'd1;
        end
      end else begin
        gen_h <= gen_h + 10'd1;
      end
      gh_d1 <= gen_h;  gh_d2 <= gh_d1;
      gv_d1 <= gen_v;  gv_d2 <= gv_d1;
      gf_d1 <= gen_frame; gf_d2 <= gf_d1;
      hs_gen_d1 <= hs_gen;
    end
  end

  assign hs_gen = !(gen_h >= 10'(HRES + HF) && gen_h < 10'(HRES + HF + HS));
  assign vs_gen = !(gen_v >= 10'(VRES + VF) && gen_v < 10'(VRES + VF) + gen_vs);
  assign hsync_in = hs_stuck ? 1'b1 : (hs_shift ? hs_gen_d1 : hs_gen);
  assign vsync_in = vs_gen;

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_bound(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Sample point: 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gen(input int th, input int tv);
    int n;
    n = 0;
    while (!(gen_h == 10'(th) && gen_v == 10'(tv)) && n < 2 * FRAME_CYC) begin
      step();
      n++;
    end
    if (n >= 2 * FRAME_CYC) fail_bound("wait_gen");
  endtask

  // The receiver sees a vs leading edge in the cycle where the delayed
  // generator sits at (0, VRES+VF). Lock must rise exactly one clock after the
  // third such edge counted from the call.
  task automatic wait_lock(input string name);
    int  leads;
    int  n;
    bit  done;
    leads = 0;
    n = 0;
    done = 0;
    while (!done && n < 6 * FRAME_CYC) begin
      step();
      n++;
      if (gh_d2 == 10'd0 && gv_d2 == 10'(VRES + VF)) begin
        leads++;
        if (leads == 3) begin
          check({name, " locked_on_3rd_edge"}, locked, 0);
          step();
          check({name, " locked_after_3rd_edge"}, locked, 1);
          done = 1;
        end
      end
    end
    if (!done) fail_bound(name);
  endtask

  task automatic wait_err(input string name, input int bound);
    int n;
    n = 0;
    while (sync_err !== 1'b1 && n < bound) begin
      step();
      n++;
    end
    if (n >= bound) fail_bound(name);
  endtask

  // ---------------------------------------------------------------------------
  // Probe vectors: source coordinate seen by the generator, and the recovered
  // outputs expected two clocks later.
  // ---------------------------------------------------------------------------
  typedef struct {
    int   src_h;
    int   src_v;
    int   exp_h;
    int   exp_v;
    logic exp_vis;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int mism;
    int errs;
    int gmism;
    int n;
    logic prev_locked;

    vecs[0] = '{src_h: 0,  src_v: 0, exp_h: 0,  exp_v: 0, exp_vis: 1'b1};
    vecs[1] = '{src_h: 5,  src_v: 0, exp_h: 5,  exp_v: 0, exp_vis: 1'b1};
    vecs[2] = '{src_h: 6,  src_v: 0, exp_h: 6,  exp_v: 0, exp_vis: 1'b0};
    vecs[3] = '{src_h: 2,  src_v: 1, exp_h: 2,  exp_v: 1, exp_vis: 1'b1};
    vecs[4] = '{src_h: 5,  src_v: 3, exp_h: 5,  exp_v: 3, exp_vis: 1'b1};
    vecs[5] = '{src_h: 11, src_v: 3, exp_h: 11, exp_v: 3, exp_vis: 1'b0};
    vecs[6] = '{src_h: 0,  src_v: 4, exp_h: 0,  exp_v: 4, exp_vis: 1'b0};
    vecs[7] = '{src_h: 9,  src_v: 6, exp_h: 9,  exp_v: 6, exp_vis: 1'b0};
    vecs[8] = '{src_h: 11, src_v: 9, exp_h: 11, exp_v: 9, exp_vis: 1'b0};

    hs_shift = 1'b0;
    hs_stuck = 1'b0;
    gen_vs   = 10'(VS);
    reset_n  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset h", h, 0);
    check("reset v", v, 0);
    check("reset frame", frame, 0);
    check("reset locked", locked, 0);
    check("reset visible", visible, 0);
    check("reset sync_err", sync_err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Initial acquisition
    wait_lock("lock_initial");

    // Table-driven coordinate / visible probes
    for (int i = 0; i < 9; i++) begin
      wait_gen(vecs[i].src_h, vecs[i].src_v);
      step();
      step();
      check($sformatf("vec%0d h", i), h, vecs[i].exp_h);
      check($sformatf("vec%0d v", i), v, vecs[i].exp_v);
      check($sformatf("vec%0d visible", i), visible, vecs[i].exp_vis);
      check($sformatf("vec%0d locked", i), locked, 1);
    end

    // Five locked frames tracking the delayed generator every clock
    mism = 0;
    errs = 0;
    repeat (5 * FRAME_CYC) begin
      step();
      if (h !== gh_d2 || v !== gv_d2 || frame !== gf_d2) mism++;
      if (visible !== (gh_d2 < 10'(HRES) && gv_d2 < 10'(VRES))) mism++;
      if (locked !== 1'b1) mism++;
      if (sync_err !== 1'b0) errs++;
    end
    check("track5 mismatches", mism, 0);
    check("track5 sync_err pulses", errs, 0);

    // hsync delayed by one clock for one line
    wait_gen(0, 2);
    hs_shift = 1'b1;
    prev_locked = locked;
    wait_err("shift wait_err", FRAME_CYC);
    check("shift locked before error", prev_locked, 1);
    check("shift sync_err", sync_err, 1);
    check("shift locked drop", locked, 0);
    check("shift h at error", h, HRES + HF + 1);
    check("shift v at error", v, 2);
    step();
    check("shift h after shifted edge", h, HRES + HF + 1);
    check("shift sync_err second", sync_err, 1);
    wait_gen(0, 3);
    hs_shift = 1'b0;
    wait_lock("relock_shift");

    // hsync stuck high
    wait_gen(0, 1);
    hs_stuck = 1'b1;
    wait_err("stuck wait_err", FRAME_CYC);
    check("stuck h at error", h, HRES + HF + 1);
    check("stuck v at error", v, 1);
    check("stuck locked", locked, 0);
    mism = 0;
    repeat (2 * FRAME_CYC) begin
      step();
      if (h !== gh_d2 || v !== gv_d2) mism++;
      if (visible !== 1'b0 || locked !== 1'b0) mism++;
    end
    check("stuck free-run mismatches", mism, 0);
    wait_gen(0, 1);
    hs_stuck = 1'b0;
    wait_lock("relock_stuck");

    // Generator vsync one line too wide
    wait_gen(0, 1);
    gen_vs = 10'd3;
    wait_err("vs3 wait_err", 2 * FRAME_CYC);
    check("vs3 v at error", v, VFULL - 1);
    check("vs3 h at error", h, 1);
    check("vs3 locked", locked, 0);
    mism = 0;
    gmism = 0;
    repeat (5 * FRAME_CYC) begin
      step();
      if (locked !== 1'b0) mism++;
      if (dut.good !== 4'd0) gmism++;
    end
    check("vs3 locked asserted cycles", mism, 0);
    check("vs3 good nonzero cycles", gmism, 0);
    wait_gen(0, 1);
    gen_vs = 10'(VS);
    wait_lock("relock_vs");

    // Asynchronous reset mid-line while locked
    wait_gen(3, 2);
    check("pre-reset frame nonzero", (frame != 8'd0), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset h", h, 0);
    check("async reset v", v, 0);
    check("async reset frame", frame, 0);
    check("async reset locked", locked, 0);
    check("async reset visible", visible, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_lock("relock_reset");

    // Run to the 255 -> 0 frame wrap
    mism = 0;
    n = 0;
    while (!(gf_d2 == 8'd255 && gv_d2 == 10'(VFULL - 1) && gh_d2 == 10'(HFULL - 1))
           && n < 300 * FRAME_CYC) begin
      step();
      n++;
      if (h !== gh_d2 || v !== gv_d2 || frame !== gf_d2 || locked !== 1'b1) mism++;
    end
    if (n >= 300 * FRAME_CYC) fail_bound("wrap wait");
    check("wrap tracking mismatches", mism, 0);
    check("wrap frame before", frame, 255);
    check("wrap v before", v, VFULL - 1);
    check("wrap h before", h, HFULL - 1);
    step();
    check("wrap frame after", frame, 0);
    check("wrap v after", v, 0);
    check("wrap h after", h, 0);
    check("wrap locked", locked, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
